// File: rtl/fb_alu_arbiter.sv
// fb_alu_arbiter: round-robin sharing of one combinational fb_alu between two
// requesters. It keeps a single op in flight: grant, execute, then respond.
//
// Handshake: a request transfers in a cycle where reqN_valid && reqN_ready are
// both high at the rising edge. A response transfers in a cycle where
// rspN_valid && rspN_ready are both high at the rising edge. reqN_ready is
// asserted only in IDLE, and only for the grant winner. rsp<owner>_valid stays
// high with stable rsp_* until the owner accepts the response.
module fb_alu_arbiter #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 19,
   parameter int FLAG_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic [XLEN-1:0]   req0_op1,
   input  logic [XLEN-1:0]   req0_op2,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [CTRL_W-1:0] req1_ctrl,
   input  logic [XLEN-1:0]   req1_op1,
   input  logic [XLEN-1:0]   req1_op2,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [XLEN-1:0]   rsp_res,
   output logic [FLAG_W-1:0] rsp_flags,
   output logic              rsp_flags_we,
   output logic              rsp_err,
   output logic [CTRL_W-1:0] alu_control,
   output logic [XLEN-1:0]   alu_op1,
   output logic [XLEN-1:0]   alu_op2,
   input  logic [XLEN-1:0]   alu_res,
   input  logic [FLAG_W-1:0] alu_csr,
   input  logic              alu_csr_write,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic              rr_ptr;
   logic              owner;
   logic              grant0, grant1;
   logic              legal;
   logic [CTRL_W-1:0] ctrl_q;
   logic [XLEN-1:0]   op1_q, op2_q;

   // A legal op select has exactly one bit set; zero and multi-hot are rejected.
   assign legal = (ctrl_q != '0) && ((ctrl_q & (ctrl_q - CTRL_W'(1))) == '0);

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp0_valid = (state == RESP) && !owner;
   assign rsp1_valid = (state == RESP) && owner;
   assign dbg_state  = state;

   // Next-state, grant selection and ALU drive; the ALU sees zeros outside EXEC.
   always_comb begin
      state_nxt   = state;
      grant0      = 1'b0;
      grant1      = 1'b0;
      alu_control = '0;
      alu_op1     = '0;
      alu_op2     = '0;
      case (state)
         IDLE: begin
            if (req0_valid && (!req1_valid || !rr_ptr)) begin
               grant0 = 1'b1;
            end else if (req1_valid) begin
               grant1 = 1'b1;
            end
            if (grant0 || grant1) begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            if (legal) begin
               alu_control = ctrl_q;
            end
            alu_op1   = op1_q;
            alu_op2   = op2_q;
            state_nxt = RESP;
         end
         RESP: begin
            if (owner ? rsp1_ready : rsp0_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register, round-robin pointer and latched request of the winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         rr_ptr <= 1'b0;
         owner  <= 1'b0;
         ctrl_q <= '0;
         op1_q  <= '0;
         op2_q  <= '0;
      end else begin
         state <= state_nxt;
         if (grant0 || grant1) begin
            owner  <= grant1;
            rr_ptr <= !grant1;
            ctrl_q <= grant1 ? req1_ctrl : req0_ctrl;
            op1_q  <= grant1 ? req1_op1  : req0_op1;
            op2_q  <= grant1 ? req1_op2  : req0_op2;
         end
      end
   end

   // Response capture at the end of EXEC; held until the next EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_res      <= '0;
         rsp_flags    <= '0;
         rsp_flags_we <= 1'b0;
         rsp_err      <= 1'b0;
      end else if (state == EXEC) begin
         if (legal) begin
            rsp_res      <= alu_res;
            rsp_flags    <= alu_csr;
            rsp_flags_we <= alu_csr_write;
            rsp_err      <= 1'b0;
         end else begin
            rsp_res      <= '0;
            rsp_flags    <= '0;
            rsp_flags_we <= 1'b0;
            rsp_err      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fb_alu_arbiter.sv
// tb_fb_alu_arbiter: drives both requesters with directed and random traffic,
// stands in for fb_alu with a behavioural ALU, and checks every cycle against
// a transaction-level model of the arbiter.
module tb_fb_alu_arbiter;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 19;
   localparam int FLAG_W = 4;
   localparam int RW     = 1 + 1 + FLAG_W + XLEN;

   logic              clk, rst;
   logic              req0_valid, req0_ready, req1_valid, req1_ready;
   logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
   logic [XLEN-1:0]   req0_op1, req0_op2, req1_op1, req1_op2;
   logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [XLEN-1:0]   rsp_res;
   logic [FLAG_W-1:0] rsp_flags;
   logic              rsp_flags_we, rsp_err;
   logic [CTRL_W-1:0] alu_control;
   logic [XLEN-1:0]   alu_op1, alu_op2, alu_res;
   logic [FLAG_W-1:0] alu_csr;
   logic              alu_csr_write;
   logic [1:0]        dbg_state;

   int n_chk  = 0;
   int n_fail = 0;

   // expected responses {err, flags_we, flags, res}
   logic [RW-1:0] exp_q[$];

   fb_alu_arbiter #(.XLEN(XLEN), .CTRL_W(CTRL_W), .FLAG_W(FLAG_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
      .req0_op1(req0_op1), .req0_op2(req0_op2),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
      .req1_op1(req1_op1), .req1_op2(req1_op2),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_res(rsp_res), .rsp_flags(rsp_flags), .rsp_flags_we(rsp_flags_we),
      .rsp_err(rsp_err),
      .alu_control(alu_control), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_res(alu_res), .alu_csr(alu_csr), .alu_csr_write(alu_csr_write),
      .dbg_state(dbg_state)
   );

   // Behavioural fb_alu: {csr_write, csr, res}. Non-one-hot selects return junk
   // so that capturing an idle or illegal ALU output is visible.
   function automatic logic [XLEN+FLAG_W:0] alu_model(input logic [CTRL_W-1:0] c,
                                                      input logic [XLEN-1:0] a,
                                                      input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      int idx;
      idx = -1;
      r   = '0;
      for (int k = 0; k < CTRL_W; k++) if (c == (19'd1 << k)) idx = k;
      case (idx)
         0:  r = a + b;
         1:  r = a - b;
         2:  r = a & b;
         3:  r = a | b;
         4:  r = a ^ b;
         5:  r = a << b[4:0];
         6:  r = a >> b[4:0];
         7:  r = $signed(a) >>> b[4:0];
         8:  r = {31'd0, $signed(a) < $signed(b)};
         9:  r = {31'd0, a < b};
         10: r = b;
         11: r = a;
         12: r = ~a;
         13: r = a * b;
         14: r = a + 32'd1;
         15: r = a - 32'd1;
         16: r = (a < b) ? a : b;
         17: r = (a < b) ? b : a;
         18: r = {31'd0, a == b};
         default: return {1'b1, 4'hF, 32'hDEAD_BEEF};
      endcase
      return {idx[0], r == '0, r[31], a < b, a == b, r};
   endfunction

   assign {alu_csr_write, alu_csr, alu_res} = alu_model(alu_control, alu_op1, alu_op2);

   function automatic logic [RW-1:0] expect_rsp(input logic [CTRL_W-1:0] c,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
      if ($countones(c) == 1) return {1'b0, alu_model(c, a, b)};
      return {1'b1, {(RW-1){1'b0}}};
   endfunction

   // clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: idle/busy, cycles since grant, owner, round-robin preference.
   logic              m_busy, m_owner, m_pref;
   int                m_age;
   logic [CTRL_W-1:0] m_ctrl;
   logic [XLEN-1:0]   m_a, m_b;
   logic [RW-1:0]     last_rsp;

   // Monitor / scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      logic [RW-1:0] rsp_now;
      logic          any, win, exp_r0, exp_r1, exp_v;
      rsp_now = {rsp_err, rsp_flags_we, rsp_flags, rsp_res};
      if (rst) begin
         m_busy   = 1'b0;
         m_age    = 0;
         m_owner  = 1'b0;
         m_pref   = 1'b0;
         last_rsp = '0;
         exp_q.delete();
         chk("reset_handshake", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 0);
         chk("reset_rsp", rsp_now, 0);
         chk("reset_alu", {alu_control, alu_op1, alu_op2}, 0);
      end else begin
         any    = req0_valid || req1_valid;
         win    = (req0_valid && req1_valid) ? m_pref : req1_valid;
         exp_r0 = !m_busy && any && !win;
         exp_r1 = !m_busy && any && win;
         chk("req_ready", {req1_ready, req0_ready}, {exp_r1, exp_r0});
         exp_v = m_busy && (m_age == 2);
         chk("rsp_valid", {rsp1_valid, rsp0_valid}, {exp_v && m_owner, exp_v && !m_owner});
         if (m_busy && m_age == 1) begin
            chk("alu_drive", {alu_control, alu_op1, alu_op2},
                {(($countones(m_ctrl) == 1) ? m_ctrl : 19'd0), m_a, m_b});
         end else begin
            chk("alu_quiet", {alu_control, alu_op1, alu_op2}, 0);
         end
         if (exp_v) begin
            if (exp_q.size() == 0) begin
               chk("rsp_queue_empty", 1, 0);
            end else begin
               chk("rsp_data", rsp_now, exp_q[0]);
            end
         end else begin
            chk("rsp_hold", rsp_now, last_rsp);
         end
         // advance the model to the next cycle
         if (!m_busy && any) begin
            m_busy  = 1'b1;
            m_age   = 1;
            m_owner = win;
            m_pref  = !win;
            m_ctrl  = win ? req1_ctrl : req0_ctrl;
            m_a     = win ? req1_op1  : req0_op1;
            m_b     = win ? req1_op2  : req0_op2;
            exp_q.push_back(expect_rsp(m_ctrl, m_a, m_b));
         end else if (m_busy && m_age == 1) begin
            m_age = 2;
         end else if (m_busy && m_age == 2 && (m_owner ? rsp1_ready : rsp0_ready)) begin
            if (exp_q.size() != 0) last_rsp = exp_q.pop_front();
            m_busy = 1'b0;
            m_age  = 0;
         end
      end
   end

   // driver tasks
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit p, input bit v, input logic [CTRL_W-1:0] c,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      if (p) begin
         req1_valid = v; req1_ctrl = c; req1_op1 = a; req1_op2 = b;
      end else begin
         req0_valid = v; req0_ctrl = c; req0_op1 = a; req0_op2 = b;
      end
   endtask

   // Present a request until granted (bounded), then withdraw it.
   task automatic issue(input bit p, input logic [CTRL_W-1:0] c,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      bit got;
      got = 1'b0;
      set_req(p, 1'b1, c, a, b);
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         got = p ? req1_ready : req0_ready;
         @(posedge clk);
         #1;
      end
      set_req(p, 1'b0, '0, '0, '0);
      if (!got) begin
         n_chk++;
         n_fail++;
         $display("FAIL grant_timeout: port %0d got no ready within 30 cycles", p);
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      cyc(3);
      rst = 1'b0;
      cyc(2);

      // single req0 add
      issue(0, 19'h1, 32'd5, 32'd7);
      cyc(4);

      // both valid after reset: alternating grants starting with req0
      pulse_rst();
      set_req(0, 1'b1, 19'h2, 32'd100, 32'd1);
      set_req(1, 1'b1, 19'h4, 32'hF0F0, 32'h0FF0);
      cyc(12);
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      cyc(4);

      // illegal selects on req1
      issue(1, 19'h0, 32'd9, 32'd9);
      cyc(3);
      issue(1, 19'h3, 32'd9, 32'd9);
      cyc(3);

      // response back-pressure with req1 waiting
      rsp0_ready = 1'b0;
      issue(0, 19'h8, 32'h1234, 32'h00FF);
      set_req(1, 1'b1, 19'h10, 32'd3, 32'd4);
      cyc(6);
      rsp0_ready = 1'b1;
      cyc(2);
      set_req(1, 1'b0, '0, '0, '0);
      cyc(4);

      // reset during EXEC, then a pair that must start with req0
      issue(0, 19'h20, 32'h80, 32'd3);
      pulse_rst();
      set_req(0, 1'b1, 19'h40, 32'h80, 32'd2);
      set_req(1, 1'b1, 19'h80, 32'h7, 32'd9);
      cyc(6);
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      cyc(4);

      // reset during RESP
      rsp1_ready = 1'b0;
      issue(1, 19'h100, 32'd11, 32'd13);
      cyc(1);
      pulse_rst();
      rsp1_ready = 1'b1;
      cyc(3);

      // op sweep via req1
      for (int k = 0; k < CTRL_W; k++) begin
         issue(1, 19'd1 << k, 32'd5, 32'd7);
         cyc(2);
      end

      // random traffic
      for (int n = 0; n < 400; n++) begin
         logic [CTRL_W-1:0] c0, c1;
         c0 = ($urandom_range(0, 7) == 0) ? CTRL_W'($urandom) : (19'd1 << $urandom_range(0, 18));
         c1 = ($urandom_range(0, 7) == 0) ? CTRL_W'($urandom) : (19'd1 << $urandom_range(0, 18));
         set_req(0, 1'($urandom_range(0, 1)), c0, $urandom, $urandom);
         set_req(1, 1'($urandom_range(0, 1)), c1, $urandom, $urandom);
         rsp0_ready = ($urandom_range(0, 9) < 7);
         rsp1_ready = ($urandom_range(0, 9) < 7);
         cyc(1);
      end
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      cyc(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
